desc_queue_bram_mc: RTL and testbench
=====================================

Name: desc_queue_bram_mc

Overview:
- Multi-channel descriptor queue built on one simple-dual-port block RAM (1 write port, 1 registered read port).
- The RAM is split into NUM_CH equal circular regions. Each channel runs as an independent FIFO with its own pointers, occupancy count and flags.
- Generalises the single-struct 1r1w descriptor RAM in data width, depth and channel count, and adds FIFO control, read-valid signalling and error flags.
- Sits between the packet-descriptor producer (parser/classifier) and per-port schedulers.

Parameters:
- WIDTH, 64, descriptor width in bits.
- DEPTH_NBITS, 4, log2 of entries per channel.
- CH_NBITS, 2, log2 of channel count.
- NUM_CH, 1<<CH_NBITS, channel count.
- AFULL_TH, (1<<DEPTH_NBITS)-2, almost-full assertion threshold (count >= AFULL_TH).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- wr  in  1  enqueue request
- wr_ch  in  CH_NBITS  target channel for enqueue
- din  in  WIDTH  descriptor to enqueue
- rd  in  1  dequeue request
- rd_ch  in  CH_NBITS  channel to dequeue from
- dout  out  WIDTH  dequeued descriptor (registered)
- dout_valid  out  1  dout carries a dequeued descriptor this cycle
- dout_ch  out  CH_NBITS  channel dout belongs to
- empty  out  NUM_CH  per-channel empty
- full  out  NUM_CH  per-channel full
- afull  out  NUM_CH  per-channel almost-full
- count  out  NUM_CH*(DEPTH_NBITS+1)  packed per-channel occupancy; channel c sits at bits [c*(DEPTH_NBITS+1) +: DEPTH_NBITS+1]
- ovf_err  out  1  sticky: enqueue attempted to a full channel
- udf_err  out  1  sticky: dequeue attempted from an empty channel

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high (rst).
- Reset values:
  - All write pointers, read pointers and counts = 0.
  - empty = all 1; full = 0; afull = 0.
  - dout_valid = 0; ovf_err = 0; udf_err = 0.
  - dout and dout_ch reset to 0.
  - RAM contents are not reset.
- RAM address = {channel, pointer[DEPTH_NBITS-1:0]}. Pointers are DEPTH_NBITS wide and wrap naturally from 2^DEPTH_NBITS-1 to 0.
- Enqueue accept: wr=1 and full[wr_ch]=0, with full sampled before the current cycle's update.
  - din is written at wptr[wr_ch]; wptr increments.
- Dequeue accept: rd=1 and empty[rd_ch]=0, with empty sampled before the current cycle's update.
  - RAM is read at rptr[rd_ch]; rptr increments.
  - dout = that entry on cycle N+1, with dout_valid=1 and dout_ch=rd_ch.
  - Read latency is exactly 1 cycle.
- Rejected requests have no pointer, count or RAM effect.
  - Rejected wr sets ovf_err. Rejected rd sets udf_err and produces no dout_valid.
  - Sticky errors clear only on rst.
- dout holds its last value while dout_valid=0.
- Count update per channel: +1 on accepted enqueue, −1 on accepted dequeue, unchanged if both hit the same channel in one cycle.
- Flags are combinational from the registered counts:
  - empty = (count==0)
  - full = (count==2^DEPTH_NBITS)
  - afull = (count>=AFULL_TH)
- Simultaneous wr and rd, same channel:
  - Channel full: read accepted, write rejected (ovf_err set). The full flag is pre-update, so no same-cycle pass-through.
  - Channel empty: write accepted, read rejected (udf_err set). Empty is pre-update; the data is readable from the next cycle.
  - 0 < count < max: both accepted; the read returns the old head, never the entry written this cycle.
- Simultaneous wr and rd, different channels: fully independent, both may be accepted.
- RAM read-during-write to the same address cannot occur: the empty/full rules keep read and write pointers of a channel distinct whenever both are accepted.
- rst asserted mid-operation: all state returns to reset values on the next edge. A pending dout_valid from the preceding cycle is squashed to 0.
- Throughput: one enqueue and one dequeue per cycle sustained. No backpressure on dout; the consumer must accept it.

Test Plan:
- Reset, then wr ch2 with din=0xA5 → count[ch2]=1, empty[2]=0, all other channels empty; rd ch2 next cycle → one cycle later dout=0xA5, dout_valid=1, dout_ch=2, count[ch2]=0.
- Write 16 descriptors 0..15 to ch0 (DEPTH_NBITS=4) → full[0]=1; afull[0] was first asserted at count=14; a 17th wr → ovf_err=1, count stays 16; then 16 reads → data returned in order 0..15.
- Wrap-around: repeat the fill/drain 3 times on ch1, interleaved one wr + one rd per cycle at count=5 → count holds at 5, output order preserved across the pointer wrap.
- Empty ch3 with wr and rd to ch3 in the same cycle → write accepted, no dout_valid, udf_err=1, count[ch3]=1; next-cycle rd returns the written data.
- Interleaved 4-channel traffic, random channel per cycle over 1000 cycles vs a per-channel reference queue → exact data and order match, no error flags raised.
- Assert rst the cycle after an accepted rd → dout_valid=0 on the following edge, all counts 0, all channels empty, errors cleared.

Source files
------------

// File: rtl/desc_queue_bram_mc.sv
// Multi-channel descriptor queue: one simple-dual-port RAM split into NUM_CH
// circular regions, each run as an independent FIFO with a 1-cycle registered read.
module desc_queue_bram_mc #(
    parameter int WIDTH       = 64,
    parameter int DEPTH_NBITS = 4,
    parameter int CH_NBITS    = 2,
    parameter int NUM_CH      = 1 << CH_NBITS,
    parameter int AFULL_TH    = (1 << DEPTH_NBITS) - 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr,
    input  logic [CH_NBITS-1:0]             wr_ch,
    input  logic [WIDTH-1:0]                din,
    input  logic                            rd,
    input  logic [CH_NBITS-1:0]             rd_ch,
    output logic [WIDTH-1:0]                dout,
    output logic                            dout_valid,
    output logic [CH_NBITS-1:0]             dout_ch,
    output logic [NUM_CH-1:0]               empty,
    output logic [NUM_CH-1:0]               full,
    output logic [NUM_CH-1:0]               afull,
    output logic [NUM_CH*(DEPTH_NBITS+1)-1:0] count,
    output logic                            ovf_err,
    output logic                            udf_err
);

    localparam int CW = DEPTH_NBITS + 1;
    localparam int AW = CH_NBITS + DEPTH_NBITS;
    localparam logic [CW-1:0] MAX_CNT = CW'(1 << DEPTH_NBITS);
    localparam logic [CW-1:0] AF_CNT  = CW'(AFULL_TH);

    logic [WIDTH-1:0]       mem [0:(1<<AW)-1];
    logic [DEPTH_NBITS-1:0] wptr [NUM_CH];
    logic [DEPTH_NBITS-1:0] rptr [NUM_CH];
    logic [CW-1:0]          cnt  [NUM_CH];

    logic              wr_ok;
    logic              rd_ok;
    logic [NUM_CH-1:0] wr_hit;
    logic [NUM_CH-1:0] rd_hit;

    // Acceptance uses the pre-update flags, so a same-channel wr/rd never passes through.
    always_comb begin
        wr_ok  = wr & ~full[wr_ch];
        rd_ok  = rd & ~empty[rd_ch];
        wr_hit = wr_ok ? (NUM_CH'(1) << wr_ch) : '0;
        rd_hit = rd_ok ? (NUM_CH'(1) << rd_ch) : '0;
    end

    always_comb begin
        empty = '0;
        full  = '0;
        afull = '0;
        count = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            empty[c]            = (cnt[c] == '0);
            full[c]             = (cnt[c] == MAX_CNT);
            afull[c]            = (cnt[c] >= AF_CNT);
            count[c*CW +: CW]   = cnt[c];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[{wr_ch, wptr[wr_ch]}] <= din;
    end

    // Registered read port; dout holds its value between dequeues.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_ch    <= '0;
        end else begin
            dout_valid <= rd_ok;
            if (rd_ok) begin
                dout    <= mem[{rd_ch, rptr[rd_ch]}];
                dout_ch <= rd_ch;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                wptr[c] <= '0;
                rptr[c] <= '0;
                cnt[c]  <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_hit[c])
                    wptr[c] <= wptr[c] + DEPTH_NBITS'(1);
                if (rd_hit[c])
                    rptr[c] <= rptr[c] + DEPTH_NBITS'(1);
                case ({wr_hit[c], rd_hit[c]})
                    2'b10:   cnt[c] <= cnt[c] + CW'(1);
                    2'b01:   cnt[c] <= cnt[c] - CW'(1);
                    default: cnt[c] <= cnt[c];
                endcase
            end
        end
    end

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_err <= 1'b0;
            udf_err <= 1'b0;
        end else begin
            if (wr && full[wr_ch])
                ovf_err <= 1'b1;
            if (rd && empty[rd_ch])
                udf_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_desc_queue_bram_mc.sv
// Directed bench for desc_queue_bram_mc: hand-checked vectors plus a
// per-channel reference queue compared against the DUT every cycle.
module tb_desc_queue_bram_mc;

    localparam int WIDTH = 64;
    localparam int NCH   = 4;
    localparam int CW    = 5;
    localparam int DEPTH = 16;

    logic                clk;
    logic                rst;
    logic                wr;
    logic [1:0]          wr_ch;
    logic [WIDTH-1:0]    din;
    logic                rd;
    logic [1:0]          rd_ch;
    logic [WIDTH-1:0]    dout;
    logic                dout_valid;
    logic [1:0]          dout_ch;
    logic [NCH-1:0]      empty;
    logic [NCH-1:0]      full;
    logic [NCH-1:0]      afull;
    logic [NCH*CW-1:0]   count;
    logic                ovf_err;
    logic                udf_err;

    desc_queue_bram_mc dut (
        .clk        (clk),
        .rst        (rst),
        .wr         (wr),
        .wr_ch      (wr_ch),
        .din        (din),
        .rd         (rd),
        .rd_ch      (rd_ch),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ch    (dout_ch),
        .empty      (empty),
        .full       (full),
        .afull      (afull),
        .count      (count),
        .ovf_err    (ovf_err),
        .udf_err    (udf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [WIDTH-1:0] q [NCH][$];
    logic             expValid;
    logic [WIDTH-1:0] lastDout;
    logic [1:0]       lastCh;
    logic             mOvf;
    logic             mUdf;
    int               errCount;
    int               checkCount;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checkCount++;
        if (got !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Compare every observable output against the reference queues.
    task automatic checkState();
        logic [NCH-1:0] e, f, a;
        e = '0;
        f = '0;
        a = '0;
        checkOutput("dout_valid", 64'(dout_valid), 64'(expValid));
        checkOutput("dout", dout, lastDout);
        checkOutput("dout_ch", 64'(dout_ch), 64'(lastCh));
        for (int c = 0; c < NCH; c++) begin
            checkOutput($sformatf("count%0d", c), 64'(count[c*CW +: CW]), 64'(q[c].size()));
            e[c] = (q[c].size() == 0);
            f[c] = (q[c].size() == DEPTH);
            a[c] = (q[c].size() >= DEPTH - 2);
        end
        checkOutput("empty", 64'(empty), 64'(e));
        checkOutput("full", 64'(full), 64'(f));
        checkOutput("afull", 64'(afull), 64'(a));
        checkOutput("ovf_err", 64'(ovf_err), 64'(mOvf));
        checkOutput("udf_err", 64'(udf_err), 64'(mUdf));
    endtask

    task automatic applyStimulus(input logic w, input logic [1:0] wc, input logic [63:0] d,
                                 input logic r, input logic [1:0] rc);
        bit wacc, racc;
        wacc  = w && (q[wc].size() < DEPTH);
        racc  = r && (q[rc].size() != 0);
        wr    = w;
        wr_ch = wc;
        din   = d;
        rd    = r;
        rd_ch = rc;
        @(posedge clk);
        #1;
        wr = 1'b0;
        rd = 1'b0;
        expValid = racc;
        if (racc) begin
            lastDout = q[rc].pop_front();
            lastCh   = rc;
        end
        if (wacc)
            q[wc].push_back(d);
        if (w && !wacc) mOvf = 1'b1;
        if (r && !racc) mUdf = 1'b1;
        checkState();
    endtask

    task automatic doReset(input logic r);
        rst   = 1'b1;
        wr    = 1'b0;
        rd    = r;
        rd_ch = 2'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd  = 1'b0;
        for (int c = 0; c < NCH; c++) q[c].delete();
        expValid = 1'b0;
        lastDout = '0;
        lastCh   = '0;
        mOvf     = 1'b0;
        mUdf     = 1'b0;
        checkState();
    endtask

    initial begin
        logic       w, r;
        logic [1:0] wc, rc;
        errCount   = 0;
        checkCount = 0;
        rst   = 1'b1;
        wr    = 1'b0;
        wr_ch = '0;
        din   = '0;
        rd    = 1'b0;
        rd_ch = '0;
        repeat (2) @(posedge clk);
        doReset(1'b0);
        checkOutput("rst_empty", 64'(empty), 64'hF);
        checkOutput("rst_count", 64'(count), 64'h0);

        applyStimulus(1'b1, 2'd2, 64'hA5, 1'b0, 2'd0);
        checkOutput("wr2_count", 64'(count[2*CW +: CW]), 64'd1);
        checkOutput("wr2_empty", 64'(empty), 64'b1011);
        applyStimulus(1'b0, 2'd0, 64'h0, 1'b1, 2'd2);
        checkOutput("rd2_dout", dout, 64'hA5);
        checkOutput("rd2_valid", 64'(dout_valid), 64'd1);
        checkOutput("rd2_ch", 64'(dout_ch), 64'd2);
        checkOutput("rd2_count", 64'(count[2*CW +: CW]), 64'd0);

        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b1, 2'd0, 64'(i), 1'b0, 2'd0);
            checkOutput("fill0_afull", 64'(afull[0]), 64'((i + 1) >= 14));
        end
        checkOutput("fill0_full", 64'(full[0]), 64'd1);
        applyStimulus(1'b1, 2'd0, 64'h99, 1'b0, 2'd0);
        checkOutput("ovf_set", 64'(ovf_err), 64'd1);
        checkOutput("ovf_count", 64'(count[0 +: CW]), 64'd16);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, 2'd0, 64'h0, 1'b1, 2'd0);
            checkOutput("drain0", dout, 64'(i));
        end

        doReset(1'b0);
        for (int pass = 0; pass < 3; pass++) begin
            for (int k = 0; k < 5; k++)
                applyStimulus(1'b1, 2'd1, 64'(pass * 1000 + k), 1'b0, 2'd0);
            for (int k = 5; k < 45; k++)
                applyStimulus(1'b1, 2'd1, 64'(pass * 1000 + k), 1'b1, 2'd1);
            checkOutput("wrap_count", 64'(count[1*CW +: CW]), 64'd5);
            checkOutput("wrap_head", dout, 64'(pass * 1000 + 39));
            for (int k = 0; k < 5; k++)
                applyStimulus(1'b0, 2'd0, 64'h0, 1'b1, 2'd1);
            checkOutput("wrap_last", dout, 64'(pass * 1000 + 44));
        end

        applyStimulus(1'b1, 2'd3, 64'hC3, 1'b1, 2'd3);
        checkOutput("ch3_valid", 64'(dout_valid), 64'd0);
        checkOutput("ch3_udf", 64'(udf_err), 64'd1);
        checkOutput("ch3_count", 64'(count[3*CW +: CW]), 64'd1);
        applyStimulus(1'b0, 2'd0, 64'h0, 1'b1, 2'd3);
        checkOutput("ch3_dout", dout, 64'hC3);
        checkOutput("ch3_valid2", 64'(dout_valid), 64'd1);

        doReset(1'b0);
        for (int i = 0; i < 1000; i++) begin
            w  = 1'($urandom_range(0, 1));
            r  = 1'($urandom_range(0, 1));
            wc = 2'($urandom_range(0, 3));
            rc = 2'($urandom_range(0, 3));
            if (q[wc].size() == DEPTH) w = 1'b0;
            if (q[rc].size() == 0) r = 1'b0;
            applyStimulus(w, wc, {$urandom, $urandom}, r, rc);
        end
        checkOutput("rand_ovf", 64'(ovf_err), 64'd0);
        checkOutput("rand_udf", 64'(udf_err), 64'd0);

        doReset(1'b0);
        applyStimulus(1'b1, 2'd0, 64'h77, 1'b0, 2'd0);
        applyStimulus(1'b0, 2'd0, 64'h0, 1'b1, 2'd0);
        checkOutput("pre_rst_valid", 64'(dout_valid), 64'd1);
        applyStimulus(1'b1, 2'd0, 64'h78, 1'b0, 2'd0);
        doReset(1'b1);
        checkOutput("mid_rst_valid", 64'(dout_valid), 64'd0);
        checkOutput("mid_rst_count", 64'(count), 64'h0);
        checkOutput("mid_rst_empty", 64'(empty), 64'hF);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
